// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe
//  Description : Elastic pipeline of DEPTH register stages with a valid/ready
//                handshake on both ends. Bubbles collapse: a stage loads from
//                its predecessor whenever it is empty or its own contents are
//                moving on. This gives a latency of DEPTH cycles, one transfer
//                per cycle when streaming, and storage for DEPTH entries under
//                backpressure.
//
//  Ports       : clk        - sole clock, rising edge
//                rst_n      - synchronous active-low reset (priority over flush)
//                flush      - synchronous clear of all stored entries
//                in_valid   - upstream has data on in_data
//                in_ready   - pipe can accept in_data this cycle
//                in_data    - upstream data [WIDTH]
//                out_valid  - out_data holds a valid entry
//                out_ready  - downstream accepts out_data this cycle
//                out_data   - data from the last stage [WIDTH]
//                occupancy  - stored entry count (only with DFF_PIPE_OCC_EN)
//
//  Config      : define DFF_PIPE_OCC_EN to add the occupancy port and counter.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic             r_valid    [DEPTH];
    logic [WIDTH-1:0] r_data     [DEPTH];
    logic             w_src_valid[DEPTH];
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic [DEPTH-1:0] w_rdy;

    // Stage k can load when it is empty or every stage downstream of it can
    // advance. The chain is walked from the output end with a local running
    // term so the vector is only written, never read back, inside the block.
    always_comb begin : p_rdy
        logic w_chain;
        w_rdy   = '0;
        w_chain = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_chain  = !r_valid[k] || w_chain;
            w_rdy[k] = w_chain;
        end
    end

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_src_valid[k] = in_valid;
                assign w_src_data[k]  = in_data;
            end else begin : g_body
                assign w_src_valid[k] = r_valid[k-1];
                assign w_src_data[k]  = r_data[k-1];
            end

            // Data is only captured alongside a valid entry, so an empty
            // stage keeps its last value rather than toggling on bubbles.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end else if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_rdy[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_src_data[k];
                    end
                end
            end
        end
    endgenerate

    // Both handshakes are suppressed while in reset or flushing, so no
    // transfer is seen by either neighbour in those cycles.
    assign in_ready  = w_rdy[0] && !flush && rst_n;
    assign out_valid = r_valid[DEPTH-1] && !flush && rst_n;
    assign out_data  = rst_n ? r_data[DEPTH-1] : '0;

`ifdef DFF_PIPE_OCC_EN
    localparam int c_occ_w = $clog2(DEPTH + 1);

    logic [c_occ_w-1:0] r_occ;
    logic               w_in_fire;
    logic               w_out_fire;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_occ <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_occ <= r_occ + c_occ_w'(1);
        end else if (w_out_fire && !w_in_fire) begin
            r_occ <= r_occ - c_occ_w'(1);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_pipe
//  Description : Self-checking bench for dff_pipe. A WIDTH=8/DEPTH=4 instance
//                is checked every cycle against a queue model of the entries
//                and their stage positions; a WIDTH=1/DEPTH=1 instance is
//                checked from a vector table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

    localparam int DA = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: WIDTH=8, DEPTH=4 ----------------
    logic       a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
`ifdef DFF_PIPE_OCC_EN
    logic [2:0] a_occ;
    int         s_occ;
`endif

    dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occupancy (a_occ)
`endif
    );

    // ---------------- instance B: WIDTH=1, DEPTH=1 ----------------
    logic       b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0] b_in_data, b_out_data;
`ifdef DFF_PIPE_OCC_EN
    logic [0:0] b_occ;
`endif

    dff_pipe #(.WIDTH(1), .DEPTH(1)) u_dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occupancy (b_occ)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Reference model: stored entries oldest first, each with its stage index.
    int         mq_pos[$];
    logic [7:0] mq_dat[$];

    logic       s_ov, s_ir;
    logic [7:0] s_od;

    // One cycle on instance A: drive, compare against the model, then advance
    // the model across the rising edge.
    task automatic step_a(input logic iv, input logic [7:0] d, input logic ordy,
                          input logic fl, input logic rn);
        logic       e_ov, e_ir, adv;
        logic [7:0] e_od;
        int         np[$];
        logic [7:0] nd[$];
        int         p;
        @(negedge clk);
        a_in_valid  = iv;
        a_in_data   = d;
        a_out_ready = ordy;
        a_flush     = fl;
        a_rst_n     = rn;
        #1;
        e_ov = rn && !fl && (mq_pos.size() > 0) && (mq_pos[0] == DA - 1);
        // Entry can come in if any stage is free, or everything moves on.
        e_ir = rn && !fl && ((mq_pos.size() < DA) || ordy);
        e_od = e_ov ? mq_dat[0] : 8'h00;
        s_ov = a_out_valid;
        s_ir = a_in_ready;
        s_od = a_out_data;
        chk("out_valid", 32'(a_out_valid), 32'(e_ov));
        chk("in_ready", 32'(a_in_ready), 32'(e_ir));
        if (!rn || e_ov) chk("out_data", 32'(a_out_data), 32'(e_od));
`ifdef DFF_PIPE_OCC_EN
        s_occ = int'(a_occ);
        chk("occupancy", 32'(a_occ), 32'(mq_pos.size()));
`endif
        @(posedge clk);
        if (!rn || fl) begin
            mq_pos.delete();
            mq_dat.delete();
        end else begin
            for (int j = 0; j < mq_pos.size(); j++) begin
                p = mq_pos[j];
                // j older entries sit above p; the stage is blocked only if
                // they fill every slot above it and the output is stalled.
                adv = (j < DA - 1 - p) || ordy;
                if (!(adv && p == DA - 1)) begin
                    np.push_back(adv ? p + 1 : p);
                    nd.push_back(mq_dat[j]);
                end
            end
            if (iv && e_ir) begin
                np.push_back(0);
                nd.push_back(d);
            end
            mq_pos = np;
            mq_dat = nd;
        end
    endtask

    typedef struct {
        logic iv;
        logic d;
        logic ordy;
        logic e_ov;
        logic e_od;
        logic e_ir;
    } vec_t;

    initial begin
        vec_t       tbl[9];
        logic       ovh[8];
        logic [7:0] odh[8];
        logic       irh[6];

        // DEPTH=1 vectors: outputs expected in the row's cycle, before its edge.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        a_rst_n = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 1'b0; b_out_ready = 1'b0;
        @(posedge clk);

        // Reset held two cycles with in_valid high.
        step_a(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_out_data", 32'(s_od), 32'd0);
        chk("rst_in_ready", 32'(s_ir), 32'd0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("rst_release_in_ready", 32'(s_ir), 32'd1);

        // Latency and streaming.
        for (int k = 0; k < 8; k++) begin
            step_a(k < 3, (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : (k == 2) ? 8'h33 : 8'h00,
                   1'b1, 1'b0, 1'b1);
            ovh[k] = s_ov;
            odh[k] = s_od;
        end
        chk("lat_not_yet", 32'(ovh[3]), 32'd0);
        chk("lat_first_valid", 32'(ovh[4]), 32'd1);
        chk("stream_0", 32'(odh[4]), 32'h11);
        chk("stream_1", 32'(odh[5]), 32'h22);
        chk("stream_2", 32'(odh[6]), 32'h33);
        chk("stream_end", 32'(ovh[7]), 32'd0);

        // Full and backpressure.
        for (int k = 0; k < 6; k++) begin
            step_a(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, 1'b1);
            irh[k] = s_ir;
        end
        chk("full_ready_4th", 32'(irh[3]), 32'd1);
        chk("full_ready_5th", 32'(irh[4]), 32'd0);
        chk("full_ready_6th", 32'(irh[5]), 32'd0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef DFF_PIPE_OCC_EN
        chk("full_occ", 32'(s_occ), 32'd4);
`endif
        for (int k = 0; k < 5; k++) begin
            step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            if (k < 4) chk("drain_data", 32'(s_od), 32'hA0 + 32'(k));
            else       chk("drain_empty", 32'(s_ov), 32'd0);
        end

        // Bubble collapse.
        step_a(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("bubble_head", 32'(s_od), 32'h01);
`ifdef DFF_PIPE_OCC_EN
        chk("bubble_occ", 32'(s_occ), 32'd2);
`endif
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("bubble_no_gap_valid", 32'(s_ov), 32'd1);
        chk("bubble_no_gap_data", 32'(s_od), 32'h02);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Flush with both handshakes requested.
        step_a(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        chk("flush_out_valid", 32'(s_ov), 32'd0);
        chk("flush_in_ready", 32'(s_ir), 32'd0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("post_flush_valid", 32'(s_ov), 32'd0);
        chk("post_flush_ready", 32'(s_ir), 32'd1);
`ifdef DFF_PIPE_OCC_EN
        chk("post_flush_occ", 32'(s_occ), 32'd0);
`endif

        // Reset in the middle of traffic.
        step_a(1'b1, 8'h71, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 8'h72, 1'b0, 1'b0, 1'b1);
        step_a(1'b1, 8'h73, 1'b1, 1'b1, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("midrst_ready", 32'(s_ir), 32'd1);
        chk("midrst_valid", 32'(s_ov), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step_a(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
                   ($urandom % 25) == 0, ($urandom % 50) != 0);
        end

        // DEPTH=1, WIDTH=1 table: behaves as a rising-edge DFF.
        for (int r = 0; r < 9; r++) begin
            @(negedge clk);
            b_rst_n     = 1'b1;
            b_in_valid  = tbl[r].iv;
            b_in_data   = tbl[r].d;
            b_out_ready = tbl[r].ordy;
            #1;
            chk("d1_out_valid", 32'(b_out_valid), 32'(tbl[r].e_ov));
            chk("d1_in_ready", 32'(b_in_ready), 32'(tbl[r].e_ir));
            if (tbl[r].e_ov) chk("d1_out_data", 32'(b_out_data), 32'(tbl[r].e_od));
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (legal: >= 1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (legal: >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stored entries.
REQ-006 SHALL have port in_valid  input  1  upstream has data on in_data.
REQ-007 SHALL have port in_ready  output  1  pipe can accept in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream data.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  data from last stage (stage DEPTH-1).
REQ-012 SHALL have port occupancy  output  $clog2(DEPTH+1)  entry count, present only with DFF_PIPE_OCC_EN.

Function
REQ-013 SHALL hold DEPTH stages, each with a WIDTH-bit data register and a valid bit; stage 0 is input side, stage DEPTH-1 drives out_data/out_valid.
REQ-014 SHALL define stage ready: rdy[i] = !valid[i] || rdy[i+1], with rdy[DEPTH] = out_ready (bubble-collapsing).
REQ-015 SHALL drive in_ready = rdy[0] && !flush; the out_ready -> in_ready combinational path is intended.
REQ-016 SHALL accept input on a rising edge where in_valid && in_ready; the transfer loads stage 0.
REQ-017 SHALL complete an output transfer on a rising edge where out_valid && out_ready.
REQ-018 SHALL, on a rising edge where rdy[i+1] is 1, load stage i+1 from stage i (data and valid); a stage whose rdy is 0 holds its contents.
REQ-019 SHALL give latency DEPTH cycles: an entry accepted into an empty pipe at edge N shows out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles after the accept cycle.
REQ-020 SHALL sustain one transfer per cycle when in_valid and out_ready stay 1.
REQ-021 SHALL store exactly DEPTH entries when out_ready=0; in_ready SHALL then be 0.
REQ-022 SHALL preserve entry order; no entry is duplicated or dropped except by flush or reset.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, with flush=1, force out_valid=0 and in_ready=0 in that cycle and clear all valid bits at that edge; no transfer in either direction occurs that cycle.
REQ-025 SHALL give flush priority over simultaneous in_valid/out_ready; rst_n=0 SHALL have priority over flush.
REQ-026 SHALL, when DEPTH=1, behave as a single registered stage with in_ready = !valid[0] || out_ready.

Reset
REQ-027 SHALL, on a rising edge with rst_n=0, clear every valid bit and every data register to 0, and clear occupancy to 0.
REQ-028 SHALL drive out_valid=0, out_data=0 and in_ready=0 during every cycle rst_n=0, and accept nothing on those edges.
REQ-029 SHALL allow reset mid-operation: all in-flight entries are discarded, and in the first cycle after rst_n returns to 1, in_ready=1 and out_valid=0.

Configuration
REQ-030 SHALL compile the occupancy port and counter only when macro DFF_PIPE_OCC_EN is defined.
REQ-031 SHALL, with DFF_PIPE_OCC_EN defined, update occupancy each edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither, 0 on flush or reset; range 0..DEPTH.
REQ-032 SHALL, without DFF_PIPE_OCC_EN, have no occupancy port, and all other behaviour SHALL be identical.

Verification
REQ-033 SHALL verify reset: WIDTH=8, DEPTH=4, rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0, occupancy=0; in_ready=1 in the first cycle after release.
REQ-034 SHALL verify latency and streaming: push 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_valid rises 4 cycles after the first accept; outputs are 0x11,0x22,0x33 on consecutive cycles.
REQ-035 SHALL verify full and backpressure: out_ready=0, push 0xA0..0xA5 -> only 0xA0..0xA3 accepted, in_ready=0 after the 4th, occupancy=4; then out_ready=1 -> drains 0xA0..0xA3 in order.
REQ-036 SHALL verify bubble collapse: push 0x01, idle 2 cycles, push 0x02, out_ready=0 -> both are held in stages 3 and 2 with no gap, occupancy=2.
REQ-037 SHALL verify flush: 3 entries stored, assert flush with in_valid=1 and out_ready=1 -> no transfer that cycle; next cycle out_valid=0, occupancy=0, in_ready=1.
REQ-038 SHALL verify DEPTH=1, WIDTH=1: alternate d=1/0 pushes with out_ready=1 -> out_data follows one cycle later, matching a rising-edge DFF.
